full_adder_s: RTL and testbench

FULL_ADDER_S -- requirements
Module: full_adder_s

---
 rtl/full_adder_s.sv | 75 +++++++
 tb/tb_full_adder_s.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/full_adder_s.sv
// Full adder with combinational and registered outputs plus bit-serial carry chaining.
// Optional saturating carry event counter enabled by FULL_ADDER_S_CARRY_CNT_EN.
module full_adder_s #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             in_valid,
  input  logic             chain_en,
  output logic             sum,
  output logic             cout,
  output logic             sum_q,
  output logic             cout_q,
  output logic             out_valid
`ifdef FULL_ADDER_S_CARRY_CNT_EN
  ,
  output logic [CNT_W-1:0] carry_cnt
`endif
);

  logic w_ci_eff;
  logic w_sum_d;
  logic w_cout_d;
  logic r_sum;
  logic r_cout;
  logic r_valid;

  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

  // In chaining mode the carry comes from the previous registered result.
  always_comb begin
    w_ci_eff = chain_en ? r_cout : cin;
    w_sum_d  = a ^ b ^ w_ci_eff;
    w_cout_d = (a & b) | (a & w_ci_eff) | (b & w_ci_eff);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= 1'b0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_sum_d;
        r_cout <= w_cout_d;
      end
    end
  end

  assign sum_q     = r_sum;
  assign cout_q    = r_cout;
  assign out_valid = r_valid;

`ifdef FULL_ADDER_S_CARRY_CNT_EN
  logic [CNT_W-1:0] r_carry_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry_cnt <= '0;
    end else if (in_valid && w_cout_d && (r_carry_cnt != {CNT_W{1'b1}})) begin
      r_carry_cnt <= r_carry_cnt + 1'b1;
    end
  end

  assign carry_cnt = r_carry_cnt;
`endif

endmodule

// File: tb/tb_full_adder_s.sv
// Directed self-checking bench for full_adder_s; counter test runs when
// FULL_ADDER_S_CARRY_CNT_EN is defined.
module tb_full_adder_s;

`ifdef FULL_ADDER_S_CARRY_CNT_EN
  localparam int unsigned TbCntW = 2;
`else
  localparam int unsigned TbCntW = 8;
`endif

  logic clk;
  logic rst_n;
  logic a;
  logic b;
  logic cin;
  logic in_valid;
  logic chain_en;
  logic sum;
  logic cout;
  logic sum_q;
  logic cout_q;
  logic out_valid;
`ifdef FULL_ADDER_S_CARRY_CNT_EN
  logic [TbCntW-1:0] carry_cnt;
`endif

  int checks;
  int errors;

  full_adder_s #(
    .CNT_W(TbCntW)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .in_valid (in_valid),
    .chain_en (chain_en),
    .sum      (sum),
    .cout     (cout),
    .sum_q    (sum_q),
    .cout_q   (cout_q),
    .out_valid(out_valid)
`ifdef FULL_ADDER_S_CARRY_CNT_EN
    ,
    .carry_cnt(carry_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge, then sample 1 ns after the next rising edge.
  task automatic step(input logic va, input logic vb, input logic vc, input logic vv,
                      input logic vch);
    @(negedge clk);
    a        = va;
    b        = vb;
    cin      = vc;
    in_valid = vv;
    chain_en = vch;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_sum;
  logic [7:0] exp_cout;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [3:0] exp_ser;

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    a        = 1'b0;
    b        = 1'b0;
    cin      = 1'b0;
    in_valid = 1'b0;
    chain_en = 1'b0;

    // Combinational truth table under reset, index = {a,b,cin}.
    exp_sum  = 8'b1001_0110;
    exp_cout = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      {a, b, cin} = i[2:0];
      in_valid    = i[0];
      chain_en    = i[1];
      #20;
      check($sformatf("comb_sum_%0d", i), {31'd0, sum}, {31'd0, exp_sum[i]});
      check($sformatf("comb_cout_%0d", i), {31'd0, cout}, {31'd0, exp_cout[i]});
    end
    check("rst_sum_q", {31'd0, sum_q}, 32'd0);
    check("rst_cout_q", {31'd0, cout_q}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);

    // Single registered add 1+1+0.
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("reg_sum_q", {31'd0, sum_q}, 32'd0);
    check("reg_cout_q", {31'd0, cout_q}, 32'd1);
    check("reg_out_valid", {31'd0, out_valid}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_sum_q", {31'd0, sum_q}, 32'd0);
    check("idle_cout_q", {31'd0, cout_q}, 32'd1);

    // Fresh reset, then 0b1011 + 0b0110 bit-serial.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    op_a    = 4'b1011;
    op_b    = 4'b0110;
    exp_ser = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step(op_a[i], op_b[i], 1'b1, 1'b1, 1'b1);
      check($sformatf("ser_sum_q_%0d", i), {31'd0, sum_q}, {31'd0, exp_ser[i]});
    end
    check("ser_cout_q", {31'd0, cout_q}, 32'd1);

    // Asynchronous reset mid-chain drops the stored carry.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_cout_q", {31'd0, cout_q}, 32'd0);
    check("async_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_sum_q", {31'd0, sum_q}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check("post_rst_sum_q", {31'd0, sum_q}, 32'd1);
    check("post_rst_cout_q", {31'd0, cout_q}, 32'd0);

    // chain_en toggled between valid edges: cin path, then chained carry.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("tog_cout_q", {31'd0, cout_q}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("tog_hold_cout_q", {31'd0, cout_q}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("tog_chain_sum_q", {31'd0, sum_q}, 32'd1);
    check("tog_chain_cout_q", {31'd0, cout_q}, 32'd0);

`ifdef FULL_ADDER_S_CARRY_CNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("cnt_rst", {30'd0, carry_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      check($sformatf("cnt_%0d", i), {30'd0, carry_cnt}, (i < 3) ? i + 1 : 3);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
